// File: rtl/multdiv_pkg.sv
// Shared types and constants for the iterative multiply/divide unit.
// Control decode imports the funct codes so both sides agree.
package multdiv_pkg;

    localparam int MD_WIDTH = 32;
    localparam int MD_CNT_W = 6;

    localparam logic [5:0] FUNCT_MULT = 6'h18;
    localparam logic [5:0] FUNCT_DIV  = 6'h1A;

    typedef enum logic [2:0] {
        IDLE,
        MULT,
        DIV,
        FIXUP,
        DONE,
        DZ
    } state_t;

endpackage

// File: rtl/multdiv_unit_div_step.sv
// One restoring-division step on magnitudes: trial subtract, keep or restore.
// rem_in is the already shifted-in partial remainder (WIDTH+1 bits).
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0]   rem_in,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH:0]   rem_out,
    output logic             qbit
);

    logic [WIDTH:0] diff;

    assign diff    = rem_in - {1'b0, divisor};
    assign qbit    = (rem_in >= {1'b0, divisor});
    assign rem_out = qbit ? diff : rem_in;

endmodule

// File: rtl/multdiv_unit.sv
// Iterative signed 32x32 multiply (radix-2 Booth) and restoring divide.
// Writes HI/LO on completion; flags divide-by-zero with a one-cycle pulse.
module multdiv_unit
    import multdiv_pkg::*;
#(
    parameter int WIDTH = MD_WIDTH,
    parameter int CNT_W = MD_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start_mult,
    input  logic             start_div,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             divby0flag
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    // acc holds the Booth upper half (two guard bits) or the remainder
    logic [WIDTH+1:0] acc;
    logic [WIDTH-1:0] mq;
    logic             qm1;
    logic [WIDTH+1:0] mcand;
    logic             neg_q;
    logic             neg_r;

    logic [WIDTH+1:0] sum;
    logic [WIDTH+1:0] booth_acc;
    logic [WIDTH-1:0] booth_mq;
    logic [WIDTH:0]   ds_rem;
    logic             ds_q;
    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;
    logic             go_mult;
    logic             go_div;
    logic             go_dz;

    assign mag_a = op_a[WIDTH-1] ? -op_a : op_a;
    assign mag_b = op_b[WIDTH-1] ? -op_b : op_b;

    assign go_mult = start_mult;
    assign go_div  = start_div && !start_mult && (|op_b);
    assign go_dz   = start_div && !start_mult && !(|op_b);

    always_comb begin
        sum = acc;
        unique case ({mq[0], qm1})
            2'b01:   sum = acc + mcand;
            2'b10:   sum = acc - mcand;
            default: sum = acc;
        endcase
        booth_acc = {sum[WIDTH+1], sum[WIDTH+1:1]};
        booth_mq  = {sum[0], mq[WIDTH-1:1]};
    end

    div_step #(.WIDTH(WIDTH)) u_div_step (
        .rem_in  ({acc[WIDTH-1:0], mq[WIDTH-1]}),
        .divisor (mcand[WIDTH-1:0]),
        .rem_out (ds_rem),
        .qbit    (ds_q)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            divby0flag <= 1'b0;
            hi         <= '0;
            lo         <= '0;
            cnt        <= '0;
            acc        <= '0;
            mq         <= '0;
            qm1        <= 1'b0;
            mcand      <= '0;
            neg_q      <= 1'b0;
            neg_r      <= 1'b0;
        end else begin
            done       <= 1'b0;
            divby0flag <= 1'b0;
            unique case (state)
                IDLE: begin
                    cnt <= '0;
                    unique case (1'b1)
                        go_mult: begin
                            acc   <= '0;
                            mq    <= op_b;
                            qm1   <= 1'b0;
                            mcand <= {{2{op_a[WIDTH-1]}}, op_a};
                            busy  <= 1'b1;
                            state <= MULT;
                        end
                        go_div: begin
                            acc   <= '0;
                            mq    <= mag_a;
                            mcand <= {2'b00, mag_b};
                            neg_q <= op_a[WIDTH-1] ^ op_b[WIDTH-1];
                            neg_r <= op_a[WIDTH-1];
                            busy  <= 1'b1;
                            state <= DIV;
                        end
                        go_dz: begin
                            divby0flag <= 1'b1;
                            busy       <= 1'b1;
                            state      <= DZ;
                        end
                        default: busy <= 1'b0;
                    endcase
                end
                MULT: begin
                    acc <= booth_acc;
                    mq  <= booth_mq;
                    qm1 <= mq[0];
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        hi    <= booth_acc[WIDTH-1:0];
                        lo    <= booth_mq;
                        done  <= 1'b1;
                        state <= DONE;
                    end
                end
                DIV: begin
                    acc <= {1'b0, ds_rem};
                    mq  <= {mq[WIDTH-2:0], ds_q};
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST)
                        state <= FIXUP;
                end
                FIXUP: begin
                    lo    <= neg_q ? -mq : mq;
                    hi    <= neg_r ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
                    done  <= 1'b1;
                    state <= DONE;
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                DZ: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_multdiv_unit.sv
// Directed and random checks of multdiv_unit against a plain-arithmetic model.
// Model holds expected HI/LO; latencies come from the start-to-done timing rules.
module tb_multdiv_unit;

    logic        clk;
    logic        reset;
    logic        start_mult;
    logic        start_div;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        divby0flag;

    int n_assert;
    int n_fail;
    logic [31:0] exp_hi;
    logic [31:0] exp_lo;

    multdiv_unit dut (
        .clk        (clk),
        .reset      (reset),
        .start_mult (start_mult),
        .start_div  (start_div),
        .op_a       (op_a),
        .op_b       (op_b),
        .busy       (busy),
        .done       (done),
        .hi         (hi),
        .lo         (lo),
        .divby0flag (divby0flag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model(input bit isdiv, input logic [31:0] a,
                         input logic [31:0] b);
        longint sa;
        longint sb;
        longint p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (!isdiv) begin
            p = sa * sb;
            exp_hi = p[63:32];
            exp_lo = p[31:0];
        end else if (b != 0) begin
            p = sa / sb;
            exp_lo = p[31:0];
            p = sa % sb;
            exp_hi = p[31:0];
        end
    endtask

    // both: raise start_div alongside start_mult; pulse_at: extra start_div
    task automatic do_op(input string tag, input bit isdiv,
                         input logic [31:0] a, input logic [31:0] b,
                         input bit both, input int pulse_at);
        int cyc;
        int lat;
        bit dz;
        dz  = isdiv && (b == 0);
        lat = dz ? 1 : (isdiv ? 34 : 33);
        model(isdiv, a, b);
        @(negedge clk);
        op_a       = a;
        op_b       = b;
        start_mult = !isdiv;
        start_div  = isdiv || both;
        @(posedge clk);
        #1;
        start_mult = 1'b0;
        start_div  = 1'b0;
        op_a       = $urandom;
        op_b       = $urandom;
        cyc = 1;
        while (!done && !divby0flag && cyc < 60) begin
            chk({tag, " busy"}, 64'(busy), 64'd1);
            if (cyc == pulse_at) start_div = 1'b1;
            @(posedge clk);
            #1;
            start_div = 1'b0;
            cyc++;
        end
        chk({tag, " latency"}, 64'(cyc), 64'(lat));
        chk({tag, " busy@end"}, 64'(busy), 64'd1);
        chk({tag, " done"}, 64'(done), 64'(!dz));
        chk({tag, " divby0flag"}, 64'(divby0flag), 64'(dz));
        chk({tag, " hi"}, 64'(hi), 64'(exp_hi));
        chk({tag, " lo"}, 64'(lo), 64'(exp_lo));
        @(posedge clk);
        #1;
        chk({tag, " idle busy"}, 64'(busy), 64'd0);
        chk({tag, " idle done"}, 64'(done), 64'd0);
        chk({tag, " idle flag"}, 64'(divby0flag), 64'd0);
        chk({tag, " hold"}, {hi, lo}, {exp_hi, exp_lo});
    endtask

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        bit          rd;
        n_assert   = 0;
        n_fail     = 0;
        exp_hi     = '0;
        exp_lo     = '0;
        reset      = 1'b0;
        start_mult = 1'b0;
        start_div  = 1'b0;
        op_a       = '0;
        op_b       = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset outputs", {30'd0, busy, done, hi, lo, divby0flag},
            64'd0);
        @(negedge clk);
        reset = 1'b1;

        do_op("mult 7*-3", 1'b0, 32'd7, 32'hFFFF_FFFD, 1'b0, 0);
        do_op("mult min*min", 1'b0, 32'h8000_0000, 32'h8000_0000, 1'b0, 0);
        do_op("div -7/2", 1'b1, 32'hFFFF_FFF9, 32'd2, 1'b0, 0);
        do_op("div 7/-2", 1'b1, 32'd7, 32'hFFFF_FFFE, 1'b0, 0);
        do_op("preload", 1'b1, 32'h0ACF_1234, 32'h0000_2000, 1'b0, 0);
        chk("preload hi", 64'(hi), 64'h1234);
        chk("preload lo", 64'(lo), 64'h5678);
        do_op("div by 0", 1'b1, 32'd55, 32'd0, 1'b0, 0);
        do_op("div overflow", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 0);
        do_op("both starts", 1'b0, 32'd12345, 32'hFFFF_0F00, 1'b1, 10);

        for (int i = 0; i < 24; i++) begin
            ra = $urandom;
            rb = $urandom;
            rd = 1'($urandom_range(0, 1));
            if (i % 4 == 1) rb = 32'($signed(8'($urandom)));
            if (i % 8 == 3) rb = 32'd0;
            if (i % 8 == 5) ra = 32'h8000_0000;
            do_op("random op", rd, ra, rb, 1'b0, 0);
        end

        @(negedge clk);
        op_a      = 32'd100;
        op_b      = 32'd7;
        start_div = 1'b1;
        @(posedge clk);
        #1;
        start_div = 1'b0;
        repeat (14) begin
            @(posedge clk);
            #1;
        end
        reset = 1'b0;
        #1;
        chk("mid reset", {30'd0, busy, done, hi, lo, divby0flag}, 64'd0);
        exp_hi = '0;
        exp_lo = '0;
        @(posedge clk);
        #1;
        chk("held reset", {30'd0, busy, done, hi, lo, divby0flag}, 64'd0);
        @(negedge clk);
        reset = 1'b1;
        do_op("mult 3*4", 1'b0, 32'd3, 32'd4, 1'b0, 0);
        chk("post reset lo", 64'(lo), 64'd12);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/multdiv_unit.md
Name: multdiv_unit

Overview:
- Iterative signed 32x32 multiply/divide datapath for the multicycle MIPS core; executes mult and div (funct 0x18/0x1A).
- The control FSM starts the unit and stalls on busy. On completion the unit writes HI/LO.
- Raises the single-cycle divby0flag consumed by the opcode/exception logic.
- Sits between register-file operand latches A/B and HI/LO consumers (mfhi/mflo path of MemToReg).

Parameters:
- WIDTH, 32, operand width; HI/LO are each WIDTH bits.
- CNT_W, 6, iteration counter width; must hold WIDTH.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- start_mult  in  1  one-cycle request: signed op_a*op_b
- start_div  in  1  one-cycle request: signed op_a/op_b
- op_a  in  WIDTH  multiplicand / dividend, sampled with start
- op_b  in  WIDTH  multiplier / divisor, sampled with start
- busy  out  1  high in every non-IDLE state
- done  out  1  one-cycle pulse; hi/lo valid
- hi  out  WIDTH  product[63:32] or remainder
- lo  out  WIDTH  product[31:0] or quotient
- divby0flag  out  1  one-cycle pulse on div with op_b==0

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE.
  - busy, done, divby0flag = 0.
  - hi, lo, counter and internal registers = 0.
  - Reset mid-operation aborts immediately; no partial HI/LO write.
- States: IDLE, MULT, DIV, FIXUP, DONE, DZ.
- IDLE:
  - start_mult=1: latch operands, go to MULT.
  - start_div=1 and op_b!=0: latch operand magnitudes and signs, go to DIV.
  - start_div=1 and op_b==0: go to DZ.
  - Both starts high: mult wins; start_div is dropped.
- MULT:
  - Radix-2 Booth, one step per cycle, WIDTH cycles (counter 0..WIDTH-1).
  - Then to DONE with the 64-bit two's-complement product loaded into hi:lo.
- DIV:
  - Restoring division on magnitudes, one quotient bit per cycle, WIDTH cycles.
  - Then to FIXUP.
- FIXUP (one cycle):
  - Quotient negated if the operand signs differ; truncation toward zero.
  - Remainder negated if the dividend is negative.
  - Result loaded into lo=quotient, hi=remainder; go to DONE.
- DONE: done=1 for exactly one cycle, busy=1, then IDLE.
- DZ: divby0flag=1 for one cycle, busy=1, done=0, hi/lo unchanged, then IDLE.
- Latency, with start sampled at edge 0:
  - mult: done high in cycle WIDTH+1 (33).
  - div: done high in cycle WIDTH+2 (34).
  - div by zero: divby0flag high in cycle 1.
- Starts while busy=1 (including DONE/DZ cycles) are ignored; no queueing.
- Operand changes after the start cycle have no effect.
- hi/lo are registered, change only on entry to DONE, and hold until the next successful operation.
- Overflow case 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0, no flag (MIPS-undefined; fixed here for determinism).
- Magnitude of 0x80000000 is handled as an unsigned 2^31; WIDTH+1-bit partial remainder.

Decomposition:
- Shared package multdiv_pkg:
  - state enum (IDLE, MULT, DIV, FIXUP, DONE, DZ).
  - WIDTH/CNT_W defaults.
  - funct constants FUNCT_MULT=6'h18, FUNCT_DIV=6'h1A, so control decode and this unit agree.
- One natural combinational sub-module, div_step:
  - Inputs: partial remainder, divisor.
  - Outputs: next remainder and quotient bit.
  - Isolates the subtract/restore so it can be unit-tested.
  - Booth step stays inline.

Test Plan:
- mult op_a=7, op_b=0xFFFFFFFD (-3) -> done in cycle 33, hi=0xFFFFFFFF, lo=0xFFFFFFEB; busy high cycles 1-33.
- mult 0x80000000*0x80000000 -> hi=0x40000000, lo=0x00000000.
- div op_a=0xFFFFFFF9 (-7), op_b=2 -> done cycle 34, lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1); repeat 7/-2 -> lo=0xFFFFFFFD, hi=1.
- div op_b=0 with hi/lo preloaded 0x1234/0x5678 -> divby0flag pulse cycle 1 only, done never high, hi/lo unchanged, busy back low cycle 2.
- start_mult and start_div high together, then start_div pulsed at cycle 10 -> mult result only, second request ignored, single done pulse.
- reset asserted (low) at cycle 15 of a div, released, then mult 3*4 -> outputs 0 during reset, then hi=0, lo=12 with normal 33-cycle latency.
